gol_update_scheduler: RTL and testbench

Sequences Game-of-Life generation updates against the VGA raster so the display never shows a half-computed generation. Sits beside the VGA controller on the 25 MHz pixel clock: it watches the raster position, decides when the update engine may compute the next generation, and swaps the double-buffered cell memory only at end of frame. It also owns run, single-step and speed control and reports generation count and overruns.

---
 rtl/gol_sched_pkg.sv | 22 ++
 rtl/gol_frame_tick.sv | 33 +++
 rtl/gol_update_scheduler.sv | 145 ++++++++++++++
 tb/tb_gol_update_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_sched_pkg.sv
// Shared types and constants for the Game-of-Life update scheduler.
// Holds the scheduler state encoding, default widths and overrun-counter helpers.
package gol_sched_pkg;

    localparam int SPEED_W_DEF = 4;
    localparam int GEN_W_DEF   = 16;
    localparam int OVR_W       = 8;
    localparam logic [OVR_W-1:0] OVR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_BUSY      = 2'd2,
        ST_SWAP_WAIT = 2'd3
    } sched_state_e;

    // Saturating increment so a badly stalled engine never wraps the count back to zero.
    function automatic logic [OVR_W-1:0] ovr_inc(input logic [OVR_W-1:0] v);
        return (v == OVR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/gol_frame_tick.sv
// Registered end-of-frame detector: one pulse the cycle after the last active pixel.
module gol_frame_tick #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [$clog2(H_ACTIVE)-1:0] x_i,
    input  logic [$clog2(V_ACTIVE)-1:0] y_i,
    input  logic                        active_i,
    output logic                        frame_end_o
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    logic last_pixel_s;
    logic frame_end_q;

    assign last_pixel_s = active_i && (x_i == XW'(H_ACTIVE - 1)) && (y_i == YW'(V_ACTIVE - 1));

    // Register the last-pixel match so the pulse lands in blanking, one cycle late.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= last_pixel_s;
        end
    end

    assign frame_end_o = frame_end_q;

endmodule

// File: rtl/gol_update_scheduler.sv
// Schedules Game-of-Life generation updates against the VGA raster and swaps
// the double-buffered cell memory only at end of frame.
module gol_update_scheduler
    import gol_sched_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPEED_W  = SPEED_W_DEF,
    parameter int GEN_W    = GEN_W_DEF
) (
    input  logic                        pixelClk,
    input  logic                        rst,
    input  logic [$clog2(H_ACTIVE)-1:0] xPos,
    input  logic [$clog2(V_ACTIVE)-1:0] yPos,
    input  logic                        pixelActive,
    input  logic                        run,
    input  logic                        step,
    input  logic [SPEED_W-1:0]          speed,
    input  logic                        updDone,
    output logic                        updStart,
    output logic                        dispBuf,
    output logic                        busy,
    output logic [GEN_W-1:0]            genCount,
    output logic [OVR_W-1:0]            overrunCnt
);

    logic frame_end_s;
    logic trigger_s;
    logic consume_s;

    sched_state_e        state_q,        state_d;
    logic                step_pending_q, step_pending_d;
    logic [SPEED_W-1:0]  frame_cnt_q,    frame_cnt_d;
    logic                disp_buf_q,     disp_buf_d;
    logic [GEN_W-1:0]    gen_count_q,    gen_count_d;
    logic [OVR_W-1:0]    overrun_q,      overrun_d;
    logic                upd_start_q;
    logic                busy_q;

    gol_frame_tick #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_frame_tick (
        .clk_i       (pixelClk),
        .rst_i       (rst),
        .x_i         (xPos),
        .y_i         (yPos),
        .active_i    (pixelActive),
        .frame_end_o (frame_end_s)
    );

    assign trigger_s = frame_end_s && (step_pending_q || (run && (frame_cnt_q >= speed)));

    // Next-state logic for the FSM, frame divider, step latch and counters.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        disp_buf_d  = disp_buf_q;
        gen_count_d = gen_count_q;
        overrun_d   = overrun_q;
        consume_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_d     = ST_START;
                    frame_cnt_d = {SPEED_W{1'b0}};
                    consume_s   = 1'b1;
                end else if (frame_end_s && (frame_cnt_q != {SPEED_W{1'b1}})) begin
                    frame_cnt_d = frame_cnt_q + SPEED_W'(1'b1);
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // A completion coinciding with frame end is on time, not an overrun.
                if (updDone) begin
                    state_d = ST_SWAP_WAIT;
                end else if (frame_end_s) begin
                    overrun_d = ovr_inc(overrun_q);
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_SWAP_WAIT: begin
                if (frame_end_s) begin
                    disp_buf_d  = ~disp_buf_q;
                    gen_count_d = gen_count_q + GEN_W'(1'b1);
                    frame_cnt_d = {SPEED_W{1'b0}};
                    if (step_pending_q || (run && (speed == {SPEED_W{1'b0}}))) begin
                        state_d   = ST_START;
                        consume_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_SWAP_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A step arriving as a pending request is consumed is dropped, not re-queued.
        if (consume_s) begin
            step_pending_d = step && !step_pending_q;
        end else begin
            step_pending_d = step_pending_q || step;
        end
    end

    // State and registered outputs; updStart/busy are decoded from the next state.
    always_ff @(posedge pixelClk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            step_pending_q <= 1'b0;
            frame_cnt_q    <= {SPEED_W{1'b0}};
            disp_buf_q     <= 1'b0;
            gen_count_q    <= {GEN_W{1'b0}};
            overrun_q      <= {OVR_W{1'b0}};
            upd_start_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
            frame_cnt_q    <= frame_cnt_d;
            disp_buf_q     <= disp_buf_d;
            gen_count_q    <= gen_count_d;
            overrun_q      <= overrun_d;
            upd_start_q    <= (state_d == ST_START);
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign updStart   = upd_start_q;
    assign dispBuf    = disp_buf_q;
    assign busy       = busy_q;
    assign genCount   = gen_count_q;
    assign overrunCnt = overrun_q;

endmodule

// File: tb/tb_gol_update_scheduler.sv
// Directed bench for gol_update_scheduler on a shrunken 8x4 raster with blanking;
// expected updStart and swap events are queued and matched as the DUT produces them.
module tb_gol_update_scheduler;

    localparam int H_A   = 8;
    localparam int V_A   = 4;
    localparam int H_TOT = 10;
    localparam int V_TOT = 6;
    localparam int F     = H_TOT * V_TOT;
    // Last active pixel sits at offset (V_A-1)*H_TOT + H_A-1 = 37; updStart/swap show 2 cycles later.
    localparam int EV    = (V_A - 1) * H_TOT + (H_A - 1) + 2;

    logic        pixelClk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  xPos = 3'd0;
    logic [1:0]  yPos = 2'd0;
    logic        pixelActive = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic        updDone = 1'b0;
    logic        updStart;
    logic        dispBuf;
    logic        busy;
    logic [15:0] genCount;
    logic [7:0]  overrunCnt;

    gol_update_scheduler #(
        .H_ACTIVE (H_A),
        .V_ACTIVE (V_A),
        .SPEED_W  (4),
        .GEN_W    (16)
    ) dut (
        .pixelClk    (pixelClk),
        .rst         (rst),
        .xPos        (xPos),
        .yPos        (yPos),
        .pixelActive (pixelActive),
        .run         (run),
        .step        (step),
        .speed       (speed),
        .updDone     (updDone),
        .updStart    (updStart),
        .dispBuf     (dispBuf),
        .busy        (busy),
        .genCount    (genCount),
        .overrunCnt  (overrunCnt)
    );

    always #20 pixelClk = ~pixelClk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_at = -1;
    int done_lat = 20;
    bit auto_done = 1'b0;
    bit rst_req = 1'b1;
    bit step_req = 1'b0;
    logic [15:0] prev_gen = 16'd0;
    logic        prev_buf = 1'b0;

    int start_q[$];
    int swap_cyc_q[$];
    int swap_gen_q[$];
    bit swap_buf_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_swap(input int c, input int g, input bit b);
        swap_cyc_q.push_back(c);
        swap_gen_q.push_back(g);
        swap_buf_q.push_back(b);
    endtask

    task automatic tick();
        int p, hx, vy, e, g;
        bit b;
        @(posedge pixelClk);
        #1;
        cyc++;
        if (updStart === 1'b1) begin
            if (start_q.size() == 0) begin
                check("start_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = start_q.pop_front();
                check("start_cycle", 32'(cyc), 32'(e));
            end
            if (auto_done) done_at = cyc + done_lat;
        end
        if (start_q.size() > 0 && start_q[0] < cyc) begin
            e = start_q.pop_front();
            check("start_missing", 32'(0), 32'(e));
        end
        if (genCount !== prev_gen) begin
            if (swap_cyc_q.size() == 0) begin
                check("swap_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = swap_cyc_q.pop_front();
                g = swap_gen_q.pop_front();
                b = swap_buf_q.pop_front();
                check("swap_cycle", 32'(cyc), 32'(e));
                check("swap_gen", 32'(genCount), 32'(g));
                check("swap_buf", 32'(dispBuf), 32'(b));
            end
        end else if (dispBuf !== prev_buf) begin
            check("buf_spurious", 32'(dispBuf), 32'(prev_buf));
        end
        prev_gen = genCount;
        prev_buf = dispBuf;
        if (swap_cyc_q.size() > 0 && swap_cyc_q[0] < cyc) begin
            e = swap_cyc_q.pop_front();
            g = swap_gen_q.pop_front();
            b = swap_buf_q.pop_front();
            check("swap_missing", 32'(0), 32'(e));
        end

        rst = rst_req;
        p  = cyc % F;
        hx = p % H_TOT;
        vy = p / H_TOT;
        pixelActive = (hx < H_A) && (vy < V_A);
        xPos = pixelActive ? 3'(hx) : 3'd0;
        yPos = pixelActive ? 2'(vy) : 2'd0;
        updDone = (cyc == done_at);
        step = step_req;
        step_req = 1'b0;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic align(output int fr);
        tick();
        while ((cyc % F) != 0) tick();
        fr = cyc / F;
    endtask

    int fb, f, g, h;

    initial begin
        // Power-on reset.
        rst_req = 1'b1;
        repeat (4) tick();
        check("rst_updStart", 32'(updStart), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dispBuf", 32'(dispBuf), 32'd0);
        check("rst_genCount", 32'(genCount), 32'd0);
        check("rst_overrun", 32'(overrunCnt), 32'd0);
        rst_req = 1'b0;

        // run=1, speed=0: one generation per frame, back-to-back.
        align(fb);
        run = 1'b1; speed = 4'd0; auto_done = 1'b1;
        for (int k = 0; k <= 5; k++) start_q.push_back((fb + k) * F + EV);
        for (int k = 1; k <= 5; k++) push_swap((fb + k) * F + EV, k, bit'(k % 2));
        goto((fb + 5) * F + EV + 6);
        check("s1_genCount", 32'(genCount), 32'd5);
        check("s1_dispBuf", 32'(dispBuf), 32'd1);
        check("s1_busy", 32'(busy), 32'd1);

        // Reset while BUSY abandons the generation.
        rst_req = 1'b1; run = 1'b0; auto_done = 1'b0; done_at = -1;
        tick();
        prev_gen = 16'd0; prev_buf = 1'b0;
        tick();
        check("mid_rst_updStart", 32'(updStart), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dispBuf", 32'(dispBuf), 32'd0);
        check("mid_rst_genCount", 32'(genCount), 32'd0);
        check("mid_rst_overrun", 32'(overrunCnt), 32'd0);
        rst_req = 1'b0;
        goto((fb + 7) * F);
        f = fb + 7;

        // Two steps in one frame with run=0: exactly one generation.
        auto_done = 1'b1;
        goto(f * F + 5);  step_req = 1'b1; tick();
        goto(f * F + 10); step_req = 1'b1; tick();
        start_q.push_back(f * F + EV);
        push_swap((f + 1) * F + EV, 1, 1'b1);
        goto((f + 3) * F);
        check("s2_genCount", 32'(genCount), 32'd1);
        check("s2_busy", 32'(busy), 32'd0);

        // Engine stalls across three frame ends: overruns, no swap.
        g = f + 3;
        run = 1'b1; speed = 4'd0; auto_done = 1'b0;
        start_q.push_back(g * F + EV);
        goto((g + 3) * F + EV + 6);
        check("s3_overrun", 32'(overrunCnt), 32'd3);
        check("s3_genCount", 32'(genCount), 32'd1);
        check("s3_dispBuf", 32'(dispBuf), 32'd1);
        check("s3_busy", 32'(busy), 32'd1);
        done_at = cyc + 1; auto_done = 1'b1;
        start_q.push_back((g + 4) * F + EV);
        push_swap((g + 4) * F + EV, 2, 1'b0);
        push_swap((g + 5) * F + EV, 3, 1'b1);
        goto((g + 4) * F + EV + 6);
        run = 1'b0;
        goto((g + 5) * F + EV + 6);
        check("s3_idle_busy", 32'(busy), 32'd0);

        // updDone coincident with frameEnd in BUSY: no overrun, swap next frame end.
        h = g + 6;
        goto(h * F + 5); step_req = 1'b1; tick();
        auto_done = 1'b0;
        start_q.push_back(h * F + EV);
        goto(h * F + EV + 6);
        done_at = (h + 1) * F + EV - 1;
        push_swap((h + 2) * F + EV, 4, 1'b0);
        goto((h + 1) * F + EV + 6);
        check("s4_overrun", 32'(overrunCnt), 32'd3);
        check("s4_genCount_hold", 32'(genCount), 32'd3);
        check("s4_busy", 32'(busy), 32'd1);
        goto((h + 2) * F + EV + 6);
        check("s4_overrun_after", 32'(overrunCnt), 32'd3);
        check("s4_genCount", 32'(genCount), 32'd4);

        // run=1, speed=2 from IDLE right after a swap.
        run = 1'b1; speed = 4'd2; auto_done = 1'b1;
        start_q.push_back((h + 5) * F + EV);
        start_q.push_back((h + 9) * F + EV);
        start_q.push_back((h + 13) * F + EV);
        push_swap((h + 6) * F + EV, 5, 1'b1);
        push_swap((h + 10) * F + EV, 6, 1'b0);
        push_swap((h + 14) * F + EV, 7, 1'b1);
        goto((h + 13) * F + EV + 6);
        run = 1'b0;
        goto((h + 15) * F + 50);
        check("s5_genCount", 32'(genCount), 32'd7);
        check("s5_dispBuf", 32'(dispBuf), 32'd1);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_overrun", 32'(overrunCnt), 32'd3);
        check("start_queue_drained", 32'(start_q.size()), 32'd0);
        check("swap_queue_drained", 32'(swap_cyc_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
